par2ser_tx: RTL
===============

Name: par2ser_tx

Overview:
- Parallel-to-serial transmitter. Accepts a DATA_W-bit word through a valid/ready handshake and shifts it out on a single line with a start bit and a stop bit, least significant bit first.
- Transmit-side counterpart to the team's parallel-capture registers. Drives a serial link into a matching deserializer.
- Each bit is held for CLKS_PER_BIT clock cycles.

Parameters:
- DATA_W, 4, payload width in bits; must be >= 1.
- CLKS_PER_BIT, 4, clock cycles each line bit is held; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- din  input  DATA_W  parallel word to send; sampled only on the accept cycle.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, tx=1, busy=0, done=0, din_ready=1, bit counter=0, cycle counter=0, shift register=0.
- Reset mid-frame: the frame is aborted immediately, without waiting for a clock edge. tx returns high at once. No done pulse is produced. After rst deasserts, the block is in IDLE.
- Output timing: tx, busy and done are registered. din_ready is decoded from the state register only (state==IDLE) and has no combinational path from din_valid.
- Accept: a word is accepted at a rising edge where din_valid=1 and din_ready=1. din is copied into the shift register on that edge. Later changes on din do not affect the frame in progress.
- While din_ready=0, din_valid is ignored. The word is not queued; the source must hold it until accepted.
- State IDLE:
  - tx=1, busy=0.
  - On accept: go to START, set tx=0, busy=1, cycle counter=0.
- State START:
  - tx=0 for CLKS_PER_BIT cycles.
  - On the last of these cycles: go to DATA, set tx=shift[0], bit counter=0.
- State DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At the end of each bit, shift right by one and increment the bit counter.
  - After bit DATA_W-1: go to STOP, set tx=1.
- State STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last of these cycles: go to IDLE, busy=0, done=1 for exactly one cycle.
- Frame timing:
  - First tx low occurs on the cycle after the accept edge.
  - Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles.
  - din_ready rises in the same cycle done pulses. The earliest next accept is that cycle's edge, which gives back-to-back frames with no idle gap.
- Counters:
  - Cycle counter width: $clog2(CLKS_PER_BIT) bits, minimum 1. It wraps from CLKS_PER_BIT-1 to 0 at every bit boundary.
  - Bit counter width: $clog2(DATA_W) bits, minimum 1.
  - When CLKS_PER_BIT=1, each state advances every cycle.
- Illegal state encodings recover to IDLE with tx=1.

Test Plan:
- Reset values: assert rst with no clock edge -> tx=1, busy=0, din_ready=1, done=0 immediately.
- Single frame (DATA_W=4, CLKS_PER_BIT=4): din=4'b1011 accepted at cycle 0 -> tx over cycles 1..24 is 0,1,1,0,1,1, each level held 4 cycles. busy=1 for cycles 1..24. done=1 only in cycle 24. din_ready=0 for cycles 1..23.
- Back-to-back frames: hold din_valid=1, din=4'h5, then 4'hA as soon as the first word is accepted -> two 24-cycle frames with no idle high between the first stop bit and the second start bit. Line reads 0,1,0,1,0,1 then 0,0,1,0,1,1.
- Input isolation: accept 4'h3, then change din to 4'hC and pulse din_valid mid-frame -> the frame still carries 1,1,0,0. The mid-frame din_valid causes no second frame.
- Reset mid-frame: assert rst during DATA bit 2 -> tx=1 asynchronously and no done pulse. After release, din_ready=1; a new word 4'hF sends a correct full frame.
- Minimum timing (CLKS_PER_BIT=1, DATA_W=4): din=4'b0110 -> tx over 6 consecutive cycles is 0,0,1,1,0,1. done is asserted in cycle 6.

Source files
------------

// File: rtl/par2ser_tx_if.sv
// Handshake and serial-line bundle between a word source and par2ser_tx.
interface par2ser_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (output din, din_valid, input din_ready, tx, busy, done);
  modport slave  (input din, din_valid, output din_ready, tx, busy, done);
endinterface

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held CLKS_PER_BIT cycles. tx/busy/done are registered; din_ready is state==IDLE.
module par2ser_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input logic          clk,
  input logic          rst,
  par2ser_tx_if.slave  bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CLAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CSTOP = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic              tx_r, tx_n, busy_r, busy_n, done_r, done_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [DATA_W-1:0] shift, shift_n, shr;

  assign shr           = shift >> 1;
  assign bus.din_ready = (state == IDLE);
  assign bus.tx        = tx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
      bcnt   <= '0;
      shift  <= '0;
    end else begin
      state  <= state_n;
      tx_r   <= tx_n;
      busy_r <= busy_n;
      done_r <= done_n;
      cnt    <= cnt_n;
      bcnt   <= bcnt_n;
      shift  <= shift_n;
    end
  end

  // The stop bit's final cycle is already spent in IDLE (done pulses, busy still
  // high), so a new word can be accepted on that edge with no idle gap.
  always_comb begin
    state_n = state;
    tx_n    = tx_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    shift_n = shift;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (bus.din_valid) begin
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = '0;
          shift_n = bus.din;
        end
      end
      START: begin
        if (cnt == CLAST) begin
          state_n = DATA;
          tx_n    = shift[0];
          bcnt_n  = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CLAST) begin
          cnt_n   = '0;
          shift_n = shr;
          bcnt_n  = bcnt + 1'b1;
          tx_n    = shr[0];
          if (bcnt == BLAST) begin
            tx_n = 1'b1;
            // A one-cycle stop bit lives entirely in the IDLE/done cycle.
            if (CLKS_PER_BIT == 1) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = STOP;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CSTOP) begin
          state_n = IDLE;
          done_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
        bcnt_n  = '0;
      end
    endcase
  end
endmodule
